// File: rtl/qbus_cycle_initiator.sv
// qbus_cycle_initiator
//
// QBUS master-side data-transfer sequencer for the QSIC. With bus mastership
// already held, each accepted start runs one DATI (read) or DATO/DATOB (write)
// cycle. It drives the bus transmitters (TSYNC, TDIN, TDOUT, TWTBT, TBS7,
// TDAL) and sequences the Am2908 transceiver controls (DALtx, DALst, DALbe).
//
// Ports
//   clk20        20 MHz QBUS clock
//   reset        synchronous, active-high
//   start        request pulse, honoured only when idle
//   write        1 = DATO/DATOB, 0 = DATI
//   byte_mode    byte write (DATOB); ignored for reads. Named byte_mode
//                because "byte" is a reserved word in SystemVerilog.
//   addr, bs7    bus address and I/O-page select, latched at start
//   wdata        write data, latched at start
//   busy         high from the cycle after an accepted start through the
//                done cycle
//   done         one-cycle completion pulse (normal or timeout)
//   nxm          timeout flag, valid with done, held until the next start
//   rdata        read data, valid with done, held until the next DATI capture
//   RRPLY        asynchronous bus reply
//   RDL          received data lines
//   TSYNC, TDIN, TDOUT, TWTBT, TBS7, TDAL   bus drivers
//   DALtx, DALst, DALbe                     Am2908 direction, latch strobe,
//                                           bus enable (active-high)
module qbus_cycle_initiator #(
    parameter int ADDR_SETUP  = 3,
    parameter int ADDR_HOLD   = 2,
    parameter int DATA_SETUP  = 2,
    parameter int RDATA_DELAY = 3,
    parameter int TIMEOUT     = 200
) (
    input  logic        clk20,
    input  logic        reset,
    input  logic        start,
    input  logic        write,
    input  logic        byte_mode,
    input  logic [21:0] addr,
    input  logic        bs7,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        nxm,
    output logic [15:0] rdata,
    input  logic        RRPLY,
    input  logic [15:0] RDL,
    output logic        TSYNC,
    output logic        TDIN,
    output logic        TDOUT,
    output logic        TWTBT,
    output logic        TBS7,
    output logic [21:0] TDAL,
    output logic        DALtx,
    output logic        DALst,
    output logic        DALbe
);

    // Counter reload values: each wait runs from N-1 down to 0.
    localparam logic [7:0] C_AS = 8'(ADDR_SETUP - 1);
    localparam logic [7:0] C_AH = 8'(ADDR_HOLD - 1);
    localparam logic [7:0] C_DS = 8'(DATA_SETUP - 1);
    localparam logic [7:0] C_RD = 8'(RDATA_DELAY - 1);
    localparam logic [7:0] C_TO = 8'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        SYNC,
        DSETUP,
        DIN,
        RWAIT,
        DOUT,
        END,
        FAIL,
        DONE
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic        lat_write;
    logic        lat_byte;
    logic [15:0] lat_wdata;

    // Reply synchronizer; rply_p1 is the synchronized reply.
    logic rply_p0;
    logic rply_p1;

    always_ff @(posedge clk20) begin
        if (reset) begin
            rply_p0 <= 1'b0;
            rply_p1 <= 1'b0;
        end else begin
            rply_p0 <= RRPLY;
            rply_p1 <= rply_p0;
        end
    end

    // Latched request fields carry no reset: they are only read after a
    // start has loaded them.
    always_ff @(posedge clk20) begin
        if (state == IDLE && start && !reset) begin
            lat_write <= write;
            lat_byte  <= byte_mode;
            lat_wdata <= wdata;
        end
    end

    always_ff @(posedge clk20) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            nxm   <= 1'b0;
            rdata <= 16'd0;
            TSYNC <= 1'b0;
            TDIN  <= 1'b0;
            TDOUT <= 1'b0;
            TWTBT <= 1'b0;
            TBS7  <= 1'b0;
            TDAL  <= 22'd0;
            DALtx <= 1'b0;
            DALst <= 1'b0;
            DALbe <= 1'b0;
        end else begin
            // done and DALst are single-cycle pulses.
            done  <= 1'b0;
            DALst <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ADDR;
                        cnt   <= C_AS;
                        busy  <= 1'b1;
                        nxm   <= 1'b0;
                        TDAL  <= addr;
                        TBS7  <= bs7;
                        TWTBT <= write;
                        DALtx <= 1'b1;
                        DALst <= 1'b1;
                    end
                end

                ADDR: begin
                    // Output latch was strobed last cycle; enable it now.
                    DALbe <= 1'b1;
                    if (cnt == 8'd0) begin
                        state <= SYNC;
                        cnt   <= C_AH;
                        TSYNC <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                SYNC: begin
                    if (cnt == 8'd0) begin
                        if (lat_write) begin
                            // Bus enable stays on while the latch is reloaded
                            // with data, so it never toggles on the edge
                            // where TDAL switches from address to data.
                            state <= DSETUP;
                            cnt   <= C_DS;
                            TWTBT <= lat_byte;
                            TDAL  <= {6'b0, lat_wdata};
                            DALst <= 1'b1;
                        end else begin
                            // TDAL is left unchanged while the transceiver
                            // turns around to receive.
                            state <= DIN;
                            cnt   <= C_TO;
                            TWTBT <= 1'b0;
                            DALbe <= 1'b0;
                            DALtx <= 1'b0;
                            TDIN  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                DSETUP: begin
                    if (cnt == 8'd0) begin
                        state <= DOUT;
                        cnt   <= C_TO;
                        TDOUT <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                DIN: begin
                    // A reply seen in the last timeout cycle still wins.
                    if (rply_p1) begin
                        state <= RWAIT;
                        cnt   <= C_RD;
                    end else if (cnt == 8'd0) begin
                        state <= FAIL;
                        done  <= 1'b1;
                        nxm   <= 1'b1;
                        TSYNC <= 1'b0;
                        TDIN  <= 1'b0;
                        TWTBT <= 1'b0;
                        TBS7  <= 1'b0;
                        TDAL  <= 22'd0;
                        DALtx <= 1'b0;
                        DALbe <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                RWAIT: begin
                    if (cnt == 8'd0) begin
                        state <= END;
                        rdata <= RDL;
                        TDIN  <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                DOUT: begin
                    if (rply_p1) begin
                        state <= END;
                        TDOUT <= 1'b0;
                    end else if (cnt == 8'd0) begin
                        state <= FAIL;
                        done  <= 1'b1;
                        nxm   <= 1'b1;
                        TSYNC <= 1'b0;
                        TDOUT <= 1'b0;
                        TWTBT <= 1'b0;
                        TBS7  <= 1'b0;
                        TDAL  <= 22'd0;
                        DALtx <= 1'b0;
                        DALbe <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                END: begin
                    // No watchdog here: a slave that never negates reply
                    // holds the bus.
                    if (!rply_p1) begin
                        state <= DONE;
                        done  <= 1'b1;
                        TSYNC <= 1'b0;
                        TWTBT <= 1'b0;
                        TBS7  <= 1'b0;
                        TDAL  <= 22'd0;
                        DALtx <= 1'b0;
                        DALbe <= 1'b0;
                    end
                end

                // Done cycle: not yet IDLE, so a coincident start is dropped.
                FAIL, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qbus_cycle_initiator.sv
module tb_qbus_cycle_initiator;

    localparam int AS = 3;
    localparam int AH = 2;
    localparam int DS = 2;
    localparam int RD = 3;
    localparam int TO = 200;

    logic        clk20;
    logic        reset;
    logic        start;
    logic        write;
    logic        byte_mode;
    logic [21:0] addr;
    logic        bs7;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        nxm;
    logic [15:0] rdata;
    logic        RRPLY;
    logic [15:0] RDL;
    logic        TSYNC;
    logic        TDIN;
    logic        TDOUT;
    logic        TWTBT;
    logic        TBS7;
    logic [21:0] TDAL;
    logic        DALtx;
    logic        DALst;
    logic        DALbe;

    qbus_cycle_initiator #(
        .ADDR_SETUP (AS),
        .ADDR_HOLD  (AH),
        .DATA_SETUP (DS),
        .RDATA_DELAY(RD),
        .TIMEOUT    (TO)
    ) dut (
        .clk20    (clk20),
        .reset    (reset),
        .start    (start),
        .write    (write),
        .byte_mode(byte_mode),
        .addr     (addr),
        .bs7      (bs7),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .nxm      (nxm),
        .rdata    (rdata),
        .RRPLY    (RRPLY),
        .RDL      (RDL),
        .TSYNC    (TSYNC),
        .TDIN     (TDIN),
        .TDOUT    (TDOUT),
        .TWTBT    (TWTBT),
        .TBS7     (TBS7),
        .TDAL     (TDAL),
        .DALtx    (DALtx),
        .DALst    (DALst),
        .DALbe    (DALbe)
    );

    initial clk20 = 1'b0;
    always #25 clk20 = ~clk20;

    int errors = 0;
    int checks = 0;

    // One transaction record. lat: cycles from TDIN/TDOUT rising to the
    // slave raising RRPLY (-1 = RRPLY already high, a stuck slave).
    // hold: cycles RRPLY stays high after TDIN/TDOUT fall.
    // restart: 0 none, 1 extra start 5 cycles in, 2 extra start on done.
    // exp_done < 0 means no tabulated expectation (random record).
    typedef struct {
        logic        wr;
        logic        bm;
        logic        b7;
        logic [21:0] a;
        logic [15:0] wd;
        logic [15:0] rdl;
        int          lat;
        int          hold;
        int          restart;
        int          exp_done;
        logic        exp_nxm;
        logic [15:0] exp_rdata;
    } vec_t;

    logic [15:0] model_rdata;

    task automatic chk(input string name, input int c, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, c, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk20);
        #1;
    endtask

    function automatic vec_t mk(input logic wr, input logic bm, input logic b7,
                                input logic [21:0] a, input logic [15:0] wd,
                                input logic [15:0] rdl, input int lat,
                                input int hold, input int restart,
                                input int exp_done, input logic exp_nxm,
                                input logic [15:0] exp_rdata);
        vec_t v;
        v.wr = wr; v.bm = bm; v.b7 = b7; v.a = a; v.wd = wd; v.rdl = rdl;
        v.lat = lat; v.hold = hold; v.restart = restart;
        v.exp_done = exp_done; v.exp_nxm = exp_nxm; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // Runs one transaction starting in the current cycle (cycle 0) and checks
    // every output in every cycle against the timeline the protocol rules
    // give for this record.
    task automatic run_txn(input vec_t v);
        int td, tr, tacc, te, dn, dn_seen, acnt, hcnt;
        bit fail, seen, rply, active;
        logic [15:0] new_rd;
        logic [9:0] ev, av;
        logic [21:0] etdal;
        bit care;

        // Reference timeline, cycle numbers relative to the start cycle.
        td   = 1 + AS + AH + (v.wr ? DS : 0);      // first TDIN/TDOUT cycle
        tr   = (v.lat < 0) ? -10 : td + v.lat;      // RRPLY rises
        tacc = (tr + 2 > td) ? tr + 2 : td;         // reply seen through sync
        fail = (tacc > td + TO - 1);
        if (fail) begin
            dn = td + TO;
            te = dn;
        end else begin
            te = tacc + 1 + (v.wr ? 0 : RD);        // TDIN/TDOUT negated
            dn = te + v.hold + 3;                   // RRPLY low + 2 sync + 1
        end
        new_rd = (!v.wr && !fail) ? v.rdl : model_rdata;

        dn_seen = -1; seen = 0; acnt = 0; hcnt = 0;
        rply = (v.lat < 0);
        write = v.wr; byte_mode = v.bm; addr = v.a; bs7 = v.b7; wdata = v.wd;

        for (int c = 0; c <= dn + 2; c++) begin
            if (c > 0) begin
                ev[9] = (c <= dn);                                   // busy
                ev[8] = (c >= 1 + AS) && (c < dn);                   // TSYNC
                ev[7] = !v.wr && (c >= td) && (c < te);              // TDIN
                ev[6] = v.wr && (c >= td) && (c < te);               // TDOUT
                ev[5] = (c == dn);                                   // done
                ev[4] = (c < (v.wr ? dn : td));                      // DALtx
                ev[3] = (c == 1) || (v.wr && c == td - DS);          // DALst
                ev[2] = (c >= 2) && (c < (v.wr ? dn : td));          // DALbe
                ev[1] = (v.wr && c <= AS + AH) ||
                        (v.wr && v.bm && c >= td - DS && c < dn);    // TWTBT
                ev[0] = v.b7 && (c < dn);                            // TBS7
                av = {busy, TSYNC, TDIN, TDOUT, done, DALtx, DALst, DALbe, TWTBT, TBS7};
                chk("ctl{busy,sync,din,dout,done,tx,st,be,wtbt,bs7}", c, 64'(av), 64'(ev));

                care = 1'b1;
                etdal = 22'd0;
                if (c <= AS + AH) etdal = v.a;
                else if (v.wr && c >= td - DS && c < dn) etdal = {6'b0, v.wd};
                else if (c >= dn) etdal = 22'd0;
                else care = 1'b0;
                if (care) chk("TDAL", c, 64'(TDAL), 64'(etdal));

                chk("nxm", c, 64'(nxm), 64'(fail && c >= dn));
                if (c >= dn) chk("rdata", c, 64'(rdata), 64'(new_rd));
                if (c == 1) chk("rdata_held", c, 64'(rdata), 64'(model_rdata));
                if (done && dn_seen < 0) dn_seen = c;
            end

            // Slave: reacts to TDIN/TDOUT as sampled in this cycle.
            active = TDIN | TDOUT;
            if (active) begin
                seen = 1;
                if (v.lat >= 0 && acnt == v.lat) rply = 1;
                acnt++;
            end else if (seen && rply) begin
                if (hcnt == v.hold) rply = 0;
                else hcnt++;
            end
            RRPLY = rply;
            RDL   = rply ? v.rdl : 16'($urandom);

            start = (c == 0) || (v.restart == 1 && c == 5) || (v.restart == 2 && c == dn);
            step();
        end

        chk("done_at", 0, 64'(dn_seen), 64'(v.exp_done >= 0 ? v.exp_done : dn));
        if (v.exp_done >= 0) begin
            chk("tbl_nxm", dn_seen, 64'(nxm), 64'(v.exp_nxm));
            chk("tbl_rdata", dn_seen, 64'(rdata), 64'(v.exp_rdata));
        end
        model_rdata = new_rd;
        start = 1'b0;
        RRPLY = 1'b0;
        repeat (3) step();
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        #(50 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; write = 1'b0; byte_mode = 1'b0;
        addr = 22'd0; bs7 = 1'b0; wdata = 16'd0; RRPLY = 1'b0; RDL = 16'd0;
        model_rdata = 16'd0;
        repeat (3) step();
        chk("reset_state", 0,
            64'({busy, done, nxm, rdata, TSYNC, TDIN, TDOUT, TWTBT, TBS7, TDAL, DALtx, DALst, DALbe}),
            64'd0);
        reset = 1'b0;
        step();

        //          wr   bm   b7   addr          wdata        rdl          lat   hold rs done nxm  rdata
        tbl[0] = mk(1'b0,1'b0,1'b1,22'o17777520, 16'o000000,  16'o123456,   4,  0, 0,  19, 1'b0, 16'o123456);
        tbl[1] = mk(1'b1,1'b0,1'b0,22'o00001000, 16'o052525,  16'o000000,   4,  1, 0,  19, 1'b0, 16'o123456);
        tbl[2] = mk(1'b1,1'b1,1'b1,22'o17777001, 16'o000177,  16'o000000,   0,  0, 0,  14, 1'b0, 16'o123456);
        tbl[3] = mk(1'b0,1'b0,1'b0,22'o00400000, 16'o000000,  16'o111111,1000,  0, 0, 206, 1'b1, 16'o123456);
        tbl[4] = mk(1'b0,1'b0,1'b0,22'o00000002, 16'o000000,  16'o000777,   0,  0, 1,  15, 1'b0, 16'o000777);
        tbl[5] = mk(1'b0,1'b0,1'b1,22'h2AAAAA,   16'o000000,  16'hBEEF,    -1,  2, 2,  15, 1'b0, 16'hBEEF);
        tbl[6] = mk(1'b0,1'b0,1'b0,22'h155555,   16'o000000,  16'h1234,   197,  0, 0, 212, 1'b0, 16'h1234);
        tbl[7] = mk(1'b0,1'b0,1'b0,22'h000004,   16'o000000,  16'h4321,   198,  0, 0, 206, 1'b1, 16'h1234);
        tbl[8] = mk(1'b1,1'b0,1'b0,22'h000006,   16'hA5A5,    16'o000000, 197,  0, 0, 211, 1'b0, 16'h1234);
        tbl[9] = mk(1'b1,1'b1,1'b0,22'h000008,   16'h5A5A,    16'o000000, 198,  0, 0, 208, 1'b1, 16'h1234);

        for (int i = 0; i < 10; i++) run_txn(tbl[i]);

        // Reset while in DIN, then a normal cycle.
        write = 1'b0; byte_mode = 1'b0; addr = 22'o17777520; bs7 = 1'b1;
        start = 1'b1; RRPLY = 1'b0;
        step();
        start = 1'b0;
        for (int c = 1; c < 9; c++) step();
        chk("rst_pre_din", 9, 64'({TSYNC, TDIN}), 64'(2'b11));
        reset = 1'b1;
        step();
        chk("rst_clear", 10,
            64'({busy, done, nxm, rdata, TSYNC, TDIN, TDOUT, TWTBT, TBS7, TDAL, DALtx, DALst, DALbe}),
            64'd0);
        reset = 1'b0;
        model_rdata = 16'd0;
        for (int c = 11; c < 14; c++) begin
            step();
            chk("rst_no_done", c, 64'({done, busy, TSYNC}), 64'd0);
        end
        run_txn(mk(1'b0, 1'b0, 1'b0, 22'o00000100, 16'd0, 16'h5A5A, 2, 1, 0, 18, 1'b0, 16'h5A5A));

        // Randomized transactions against the timeline model.
        for (int n = 0; n < 30; n++) begin
            int r;
            rv.wr = 1'($urandom); rv.bm = 1'($urandom); rv.b7 = 1'($urandom);
            rv.a = 22'($urandom); rv.wd = 16'($urandom); rv.rdl = 16'($urandom);
            r = int'($urandom_range(0, 9));
            if (r == 0) rv.lat = -1;
            else if (r == 1) rv.lat = int'($urandom_range(196, 199));
            else rv.lat = int'($urandom_range(0, 20));
            rv.hold = int'($urandom_range(0, 3));
            rv.restart = int'($urandom_range(0, 2));
            rv.exp_done = -1; rv.exp_nxm = 1'b0; rv.exp_rdata = 16'd0;
            run_txn(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
